// File: rtl/pc_debug_ctrl.sv
// pc_debug_ctrl: debug controller for a fetch pipeline. It provides four PC
// breakpoint slots, HALT/RUN commands and an optional single-step mode.
// Single-step is compiled in only when PC_DBG_STEP_EN is defined. Without it
// there is no STEP state, STEP is treated as a NOP and cmd_ready is tied high.
module pc_debug_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_valid,
  input  logic [2:0]  cmd_op,
  input  logic [1:0]  cmd_idx,
  input  logic [31:0] cmd_addr,
  output logic        cmd_ready,
  input  logic [31:0] pc_i,
  input  logic        pc_valid_i,
  output logic        stall_req,
  output logic        halted,
  output logic        hit_valid,
  output logic [1:0]  hit_idx,
  output logic [15:0] hit_cnt
);

  localparam logic [2:0] OP_HALT   = 3'd1;
  localparam logic [2:0] OP_RUN    = 3'd2;
`ifdef PC_DBG_STEP_EN
  localparam logic [2:0] OP_STEP   = 3'd3;
`endif
  localparam logic [2:0] OP_SET_BP = 3'd4;
  localparam logic [2:0] OP_CLR_BP = 3'd5;

  typedef enum logic [1:0] {
    ST_RUN  = 2'd0,
    ST_HALT = 2'd1
`ifdef PC_DBG_STEP_EN
    ,
    ST_STEP = 2'd2
`endif
  } state_t;

  state_t      state_reg, state_next;
  logic        stall_reg, stall_next;
  logic        halted_reg, halted_next;
  logic        hit_valid_reg, hit_valid_next;
  logic [1:0]  hit_idx_reg, hit_idx_next;
  logic [15:0] hit_cnt_reg, hit_cnt_next;
  logic        skip_reg, skip_next;

  // Breakpoint slots store word addresses only.
  logic [29:0] bp_addr_reg [4];
  logic [3:0]  bp_en_reg;

  logic [3:0]  match;
  logic [1:0]  match_idx;
  logic        cmd_acc;
  logic        unused_bits;

  // Byte offsets never take part in matching.
  assign unused_bits = ^{cmd_addr[1:0], pc_i[1:0]};

`ifdef PC_DBG_STEP_EN
  assign cmd_ready = (state_reg != ST_STEP);
`else
  assign cmd_ready = 1'b1;
`endif

  assign cmd_acc = cmd_valid && cmd_ready;

  // Compare each slot against the current fetch word address.
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_match
      assign match[gi] = bp_en_reg[gi] && (bp_addr_reg[gi] == pc_i[31:2]);
    end
  endgenerate

  // Select the lowest-numbered matching slot.
  always_comb begin
    match_idx = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (match[i]) match_idx = i[1:0];
    end
  end

  // Next-state and registered-output logic. A breakpoint hit takes priority
  // over a HALT command that arrives in the same cycle.
  always_comb begin
    state_next     = state_reg;
    stall_next     = stall_reg;
    halted_next    = halted_reg;
    hit_valid_next = hit_valid_reg;
    hit_idx_next   = hit_idx_reg;
    hit_cnt_next   = hit_cnt_reg;
    skip_next      = skip_reg;
    case (state_reg)
      ST_RUN: begin
        // The first fetch after a resume consumes the skip flag, so the
        // address we halted on does not immediately halt again.
        if (pc_valid_i) skip_next = 1'b0;
        if (pc_valid_i && !skip_reg && (|match)) begin
          state_next     = ST_HALT;
          stall_next     = 1'b1;
          halted_next    = 1'b1;
          hit_valid_next = 1'b1;
          hit_idx_next   = match_idx;
          if (hit_cnt_reg != 16'hFFFF) hit_cnt_next = hit_cnt_reg + 16'd1;
        end else if (cmd_acc && cmd_op == OP_HALT) begin
          state_next     = ST_HALT;
          stall_next     = 1'b1;
          halted_next    = 1'b1;
          hit_valid_next = 1'b0;
        end
      end
      ST_HALT: begin
        if (cmd_acc && cmd_op == OP_RUN) begin
          state_next     = ST_RUN;
          stall_next     = 1'b0;
          halted_next    = 1'b0;
          hit_valid_next = 1'b0;
          skip_next      = 1'b1;
        end
`ifdef PC_DBG_STEP_EN
        else if (cmd_acc && cmd_op == OP_STEP) begin
          state_next     = ST_STEP;
          stall_next     = 1'b0;
          halted_next    = 1'b0;
          hit_valid_next = 1'b0;
        end
`endif
      end
`ifdef PC_DBG_STEP_EN
      ST_STEP: begin
        // Let exactly one instruction issue, then freeze again.
        if (pc_valid_i) begin
          state_next     = ST_HALT;
          stall_next     = 1'b1;
          halted_next    = 1'b1;
          hit_valid_next = 1'b0;
        end
      end
`endif
      default: begin
        state_next = ST_RUN;
      end
    endcase
  end

  // State and status registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg     <= ST_RUN;
      stall_reg     <= 1'b0;
      halted_reg    <= 1'b0;
      hit_valid_reg <= 1'b0;
      hit_idx_reg   <= 2'd0;
      hit_cnt_reg   <= 16'd0;
      skip_reg      <= 1'b0;
    end else begin
      state_reg     <= state_next;
      stall_reg     <= stall_next;
      halted_reg    <= halted_next;
      hit_valid_reg <= hit_valid_next;
      hit_idx_reg   <= hit_idx_next;
      hit_cnt_reg   <= hit_cnt_next;
      skip_reg      <= skip_next;
    end
  end

  // Breakpoint slot writes. New values take effect from the next cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 4; i++) bp_addr_reg[i] <= 30'd0;
      bp_en_reg <= 4'd0;
    end else if (cmd_acc && cmd_op == OP_SET_BP) begin
      bp_addr_reg[cmd_idx] <= cmd_addr[31:2];
      bp_en_reg[cmd_idx]   <= 1'b1;
    end else if (cmd_acc && cmd_op == OP_CLR_BP) begin
      bp_en_reg[cmd_idx]   <= 1'b0;
    end
  end

  assign stall_req = stall_reg;
  assign halted    = halted_reg;
  assign hit_valid = hit_valid_reg;
  assign hit_idx   = hit_idx_reg;
  assign hit_cnt   = hit_cnt_reg;

endmodule

// File: tb/tb_pc_debug_ctrl.sv
// tb_pc_debug_ctrl: directed and random stimulus for pc_debug_ctrl, checked
// against a mode-level behavioural model of the debug controller.
module tb_pc_debug_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid;
  logic [2:0]  cmd_op;
  logic [1:0]  cmd_idx;
  logic [31:0] cmd_addr;
  logic        cmd_ready;
  logic [31:0] pc_i;
  logic        pc_valid_i;
  logic        stall_req;
  logic        halted;
  logic        hit_valid;
  logic [1:0]  hit_idx;
  logic [15:0] hit_cnt;

  pc_debug_ctrl dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_op(cmd_op),
    .cmd_idx(cmd_idx), .cmd_addr(cmd_addr), .cmd_ready(cmd_ready),
    .pc_i(pc_i), .pc_valid_i(pc_valid_i), .stall_req(stall_req),
    .halted(halted), .hit_valid(hit_valid), .hit_idx(hit_idx),
    .hit_cnt(hit_cnt)
  );

  always #5 clk = ~clk;

`ifdef PC_DBG_STEP_EN
  localparam bit STEP_EN = 1'b1;
`else
  localparam bit STEP_EN = 1'b0;
`endif

  localparam logic [31:0] BASE = 32'hBFC00000;

  int checks = 0;
  int failures = 0;

  // Reference model: mode 0 = running, 1 = halted, 2 = single-stepping.
  int          m_mode;
  bit          m_skip;
  logic [31:0] m_bp_addr [4];
  bit          m_bp_en [4];
  bit          m_hv;
  int          m_hidx;
  int          m_cnt;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_mode = 0; m_skip = 0; m_hv = 0; m_hidx = 0; m_cnt = 0;
    for (int i = 0; i < 4; i++) begin
      m_bp_addr[i] = 32'd0;
      m_bp_en[i] = 0;
    end
  endtask

  // One clock edge of the specified behaviour, using pre-edge state.
  task automatic model_edge(input bit v, input int op, input int idx,
                            input logic [31:0] addr, input bit pcv,
                            input logic [31:0] pc);
    bit acc;
    int found;
    acc = v && (m_mode != 2);
    found = -1;
    case (m_mode)
      0: begin
        if (pcv && !m_skip)
          for (int i = 0; i < 4; i++)
            if (found < 0 && m_bp_en[i] && ((pc >> 2) == (m_bp_addr[i] >> 2))) found = i;
        if (pcv) m_skip = 0;
        if (found >= 0) begin
          m_mode = 1; m_hv = 1; m_hidx = found;
          if (m_cnt < 65535) m_cnt = m_cnt + 1;
        end else if (acc && op == 1) begin
          m_mode = 1; m_hv = 0;
        end
      end
      1: begin
        if (acc && op == 2) begin
          m_mode = 0; m_hv = 0; m_skip = 1;
        end else if (acc && op == 3 && STEP_EN) begin
          m_mode = 2; m_hv = 0;
        end
      end
      default: begin
        if (pcv) begin
          m_mode = 1; m_hv = 0;
        end
      end
    endcase
    if (acc && op == 4) begin
      m_bp_addr[idx] = addr;
      m_bp_en[idx] = 1;
    end else if (acc && op == 5) begin
      m_bp_en[idx] = 0;
    end
  endtask

  task automatic check_outputs(input string tag);
    chk({tag, "/stall_req"}, {31'd0, stall_req}, {31'd0, m_mode == 1});
    chk({tag, "/halted"},    {31'd0, halted},    {31'd0, m_mode == 1});
    chk({tag, "/hit_valid"}, {31'd0, hit_valid}, {31'd0, m_hv});
    chk({tag, "/hit_idx"},   {30'd0, hit_idx},   m_hidx);
    chk({tag, "/hit_cnt"},   {16'd0, hit_cnt},   m_cnt);
  endtask

  // One transaction: drive, check cmd_ready before the edge, check outputs after.
  task automatic cyc(input bit v, input int op, input int idx, input logic [31:0] addr,
                     input bit pcv, input logic [31:0] pc, input string tag);
    cmd_valid = v; cmd_op = op[2:0]; cmd_idx = idx[1:0]; cmd_addr = addr;
    pc_valid_i = pcv; pc_i = pc;
    #1;
    chk({tag, "/cmd_ready"}, {31'd0, cmd_ready}, {31'd0, m_mode != 2});
    @(posedge clk);
    model_edge(v, op, idx, addr, pcv, pc);
    #1;
    check_outputs(tag);
    $display("txn %s v=%0b op=%0d idx=%0d pcv=%0b pc=%h -> stall=%0b halted=%0b hv=%0b hidx=%0d cnt=%0d",
             tag, v, op, idx, pcv, pc, stall_req, halted, hit_valid, hit_idx, hit_cnt);
  endtask

  task automatic idle_inputs();
    cmd_valid = 0; cmd_op = 3'd0; cmd_idx = 2'd0; cmd_addr = 32'd0;
    pc_valid_i = 0; pc_i = 32'd0;
  endtask

  // Asynchronous reset applied between clock edges and checked immediately.
  task automatic do_reset(input string tag);
    rst = 1'b0;
    #2;
    model_reset();
    check_outputs(tag);
    chk({tag, "/cmd_ready"}, {31'd0, cmd_ready}, 32'd1);
    @(posedge clk);
    #1;
    rst = 1'b1;
    idle_inputs();
    $display("txn %s reset applied", tag);
  endtask

  initial begin
    idle_inputs();
    rst = 1'b0;
    do_reset("reset0");

    // Breakpoint on slot 1 at BASE+0x10, fetch a straight-line sequence.
    cyc(1, 4, 1, BASE + 32'h10, 0, 32'd0, "set_bp1");
    for (int k = 0; k <= 4; k++) cyc(0, 0, 0, 32'd0, 1, BASE + 4 * k, "fetch");
    chk("bp_hit/halted", {31'd0, halted}, 32'd1);
    chk("bp_hit/hit_idx", {30'd0, hit_idx}, 32'd1);
    chk("bp_hit/hit_cnt", {16'd0, hit_cnt}, 32'd1);

    // Resume: the halted address re-issues without re-hitting, next loop halts.
    cyc(1, 2, 0, 32'd0, 0, 32'd0, "resume");
    chk("resume/stall_req", {31'd0, stall_req}, 32'd0);
    cyc(0, 0, 0, 32'd0, 1, BASE + 32'h10, "reissue");
    chk("reissue/halted", {31'd0, halted}, 32'd0);
    cyc(0, 0, 0, 32'd0, 1, BASE + 32'h14, "fetch");
    for (int k = 0; k <= 4; k++) cyc(0, 0, 0, 32'd0, 1, BASE + 4 * k, "loop2");
    chk("loop2/hit_cnt", {16'd0, hit_cnt}, 32'd2);

    // Single-step from the breakpoint halt.
    cyc(1, 3, 0, 32'd0, 0, 32'd0, "step_cmd");
    chk("step/cmd_ready", {31'd0, cmd_ready}, {31'd0, !STEP_EN});
    cyc(0, 0, 0, 32'd0, 1, BASE + 32'h14, "step_fetch");
    chk("step/halted", {31'd0, halted}, 32'd1);
    chk("step/hit_valid", {31'd0, hit_valid}, {31'd0, !STEP_EN});
    cyc(1, 1, 0, 32'd0, 0, 32'd0, "halt_in_halt");
    cyc(1, 2, 0, 32'd0, 0, 32'd0, "run");
    cyc(1, 2, 0, 32'd0, 0, 32'd0, "run_in_run");
    cyc(1, 1, 0, 32'd0, 0, 32'd0, "halt_cmd");
    chk("halt_cmd/hit_valid", {31'd0, hit_valid}, 32'd0);

    // Two slots on the same address, HALT command in the same cycle as the hit.
    do_reset("reset1");
    cyc(1, 4, 0, BASE + 32'h20, 0, 32'd0, "set_bp0");
    cyc(1, 4, 2, BASE + 32'h20, 0, 32'd0, "set_bp2");
    cyc(1, 1, 0, 32'd0, 1, BASE + 32'h22, "hit_and_halt");
    chk("dual/hit_idx", {30'd0, hit_idx}, 32'd0);
    chk("dual/hit_valid", {31'd0, hit_valid}, 32'd1);

    // Clearing a slot disables it.
    cyc(1, 2, 0, 32'd0, 0, 32'd0, "run");
    cyc(1, 5, 0, 32'd0, 1, BASE + 32'h0, "clr_bp0");
    cyc(1, 5, 2, 32'd0, 0, 32'd0, "clr_bp2");
    cyc(0, 0, 0, 32'd0, 1, BASE + 32'h20, "no_hit");
    chk("cleared/halted", {31'd0, halted}, 32'd0);

    // Reset in the middle of a step.
    cyc(1, 4, 0, BASE + 32'h30, 0, 32'd0, "set_bp0");
    cyc(0, 0, 0, 32'd0, 1, BASE + 32'h30, "hit");
    cyc(1, 3, 0, 32'd0, 0, 32'd0, "step_cmd");
    do_reset("reset_mid_step");
    cyc(0, 0, 0, 32'd0, 1, BASE + 32'h30, "post_reset");
    chk("post_reset/halted", {31'd0, halted}, 32'd0);

    // Randomized traffic over a small address window so hits are frequent.
    do_reset("reset_rand");
    for (int n = 0; n < 1500; n++) begin
      bit v, pcv;
      int op, idx;
      logic [31:0] a, p;
      v   = ($urandom_range(0, 9) < 3);
      op  = $urandom_range(0, 7);
      idx = $urandom_range(0, 3);
      a   = BASE + 4 * $urandom_range(0, 7) + $urandom_range(0, 3);
      pcv = ($urandom_range(0, 9) < 7);
      p   = BASE + 4 * $urandom_range(0, 7) + $urandom_range(0, 3);
      cyc(v, op, idx, a, pcv, p, "rand");
    end

    // Saturation: preload the counter near its limit, then hit twice.
    do_reset("reset_sat");
    cyc(1, 4, 3, BASE + 32'h40, 0, 32'd0, "set_bp3");
    force dut.hit_cnt_reg = 16'hFFFE;
    release dut.hit_cnt_reg;
    m_cnt = 32'hFFFE;
    cyc(0, 0, 0, 32'd0, 1, BASE + 32'h40, "sat_hit1");
    chk("sat1/hit_cnt", {16'd0, hit_cnt}, 32'hFFFF);
    cyc(1, 2, 0, 32'd0, 0, 32'd0, "run");
    cyc(0, 0, 0, 32'd0, 1, BASE + 32'h44, "skip");
    cyc(0, 0, 0, 32'd0, 1, BASE + 32'h40, "sat_hit2");
    chk("sat2/hit_cnt", {16'd0, hit_cnt}, 32'hFFFF);
    chk("sat2/halted", {31'd0, halted}, 32'd1);
    chk("sat2/hit_idx", {30'd0, hit_idx}, 32'd3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
